// File: rtl/pad_responder_if.sv
// pad_if: DualShock serial link pins; the host is master and the pad is slave.
interface pad_if;
  logic pad_clk;
  logic att_n;
  logic cmd;
  logic dat;
  logic dat_oe;
  logic ack_n;
  modport master (output pad_clk, att_n, cmd, input dat, dat_oe, ack_n);
  modport slave (input pad_clk, att_n, cmd, output dat, dat_oe, ack_n);
endinterface

// File: rtl/pad_responder.sv
// pad_responder: DualShock digital pad emulator; define PAD_RESPONDER_ANALOG_EN for the 9-byte analog reply with sticks.
module pad_responder #(
  parameter logic [7:0] PAD_ID = 8'h41,
  parameter int ACK_DELAY = 500,
  parameter int ACK_WIDTH = 100
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  pad_if.slave pad,
  input  logic [15:0] buttons,
`ifdef PAD_RESPONDER_ANALOG_EN
  input  logic [31:0] sticks,
`endif
  output logic poll_strobe
);
`ifdef PAD_RESPONDER_ANALOG_EN
  localparam logic [7:0] ID = 8'h73;
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [7:0] ID = PAD_ID;
  localparam logic [3:0] LAST = 4'd4;
`endif
  localparam int CMAX_I = ACK_DELAY > ACK_WIDTH ? ACK_DELAY : ACK_WIDTH;
  localparam int CW = $clog2(CMAX_I + 1);
  localparam logic [CW-1:0] CMAX = CW'(CMAX_I);
  localparam logic [CW-1:0] DLY_END = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] WID_END = CW'(ACK_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE, DONE} state_t;
  state_t state;
  logic [2:0] clk_s, att_s;
  logic [1:0] cmd_s;
  logic [7:0] tx;
  logic [6:0] rx;
  logic [2:0] bit_cnt;
  logic [3:0] byte_idx;
  logic [CW-1:0] cnt;
  logic [15:0] btn_l;
`ifdef PAD_RESPONDER_ANALOG_EN
  logic [31:0] stk_l;
`endif
  logic pc_rise, pc_fall, att_rise, att_fall, hdr_ok;
  logic [7:0] rx_byte;
  assign pc_rise = clk_s[1] & ~clk_s[2];
  assign pc_fall = ~clk_s[1] & clk_s[2];
  assign att_rise = att_s[1] & ~att_s[2];
  assign att_fall = ~att_s[1] & att_s[2];
  assign rx_byte = {cmd_s[1], rx};
  assign hdr_ok = !((byte_idx == 4'd0 && rx_byte != 8'h01) || (byte_idx == 4'd1 && rx_byte != 8'h42));
  function automatic logic [7:0] reply(input logic [3:0] i);
    case (i)
      4'd1: reply = ID;
      4'd2: reply = 8'h5A;
      4'd3: reply = btn_l[7:0];
      4'd4: reply = btn_l[15:8];
`ifdef PAD_RESPONDER_ANALOG_EN
      4'd5: reply = stk_l[7:0];
      4'd6: reply = stk_l[15:8];
      4'd7: reply = stk_l[23:16];
      4'd8: reply = stk_l[31:24];
`endif
      default: reply = 8'hFF;
    endcase
  endfunction
  // two-flop synchronizers plus one history flop for edge detection on pad_clk and att_n
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_s <= 3'b111;
      att_s <= 3'b111;
      cmd_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[1:0], pad.pad_clk};
      att_s <= {att_s[1:0], pad.att_n};
      cmd_s <= {cmd_s[0], pad.cmd};
    end
  end
  // poll sequencer: shifts bytes, times the acknowledge, aborts whenever attention is released
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx <= 8'hFF;
      rx <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      cnt <= '0;
      btn_l <= '1;
`ifdef PAD_RESPONDER_ANALOG_EN
      stk_l <= '0;
`endif
      pad.dat <= 1'b1;
      pad.dat_oe <= 1'b0;
      pad.ack_n <= 1'b1;
      poll_strobe <= 1'b0;
    end else begin
      poll_strobe <= 1'b0;
      if (att_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        byte_idx <= '0;
        cnt <= '0;
        pad.dat <= 1'b1;
        pad.dat_oe <= 1'b0;
        pad.ack_n <= 1'b1;
      end else begin
        case (state)
          IDLE: if (att_fall) begin
            btn_l <= buttons;
`ifdef PAD_RESPONDER_ANALOG_EN
            stk_l <= sticks;
`endif
            tx <= 8'hFF;
            bit_cnt <= '0;
            byte_idx <= '0;
            pad.dat <= 1'b1;
            pad.dat_oe <= 1'b1;
            state <= SHIFT;
          end
          SHIFT: begin
            if (pc_fall) pad.dat <= tx[bit_cnt];
            if (pc_rise) begin
              rx <= rx_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!hdr_ok) begin
                  pad.dat_oe <= 1'b0;
                  state <= IGNORE;
                end else if (byte_idx == LAST) begin
                  pad.dat_oe <= 1'b0;
                  poll_strobe <= 1'b1;
                  state <= DONE;
                end else begin
                  tx <= reply(byte_idx + 4'd1);
                  byte_idx <= byte_idx + 4'd1;
                  cnt <= '0;
                  state <= ACK_WAIT;
                end
              end
            end
          end
          ACK_WAIT: begin
            if (pc_fall) begin
              pad.dat <= tx[bit_cnt];
              state <= SHIFT;
            end else if (cnt == DLY_END) begin
              pad.ack_n <= 1'b0;
              cnt <= '0;
              state <= ACK_PULSE;
            end else cnt <= (cnt == CMAX) ? cnt : cnt + 1'b1;
          end
          ACK_PULSE: begin
            if (pc_fall) begin
              pad.ack_n <= 1'b1;
              pad.dat <= tx[bit_cnt];
              state <= SHIFT;
            end else if (cnt == WID_END) begin
              pad.ack_n <= 1'b1;
              state <= SHIFT;
            end else cnt <= (cnt == CMAX) ? cnt : cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
